// File: rtl/fare_pkg.sv
// Shared definitions for the taxi-meter fare engine.
package fare_pkg;

  localparam int unsigned BCD_W = 16;

  localparam logic [BCD_W-1:0] FARE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_adder_4.sv
// Four-digit packed BCD adder with carry in and carry out.
module bcd_adder_4
  import fare_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             c_in,
  output logic [BCD_W-1:0] sum,
  output logic             c_out
);

  logic [4:0] dig_sum;
  logic       carry;

  // Ripple through the digits, applying the +6 decimal correction above 9.
  always_comb begin
    carry   = c_in;
    sum     = '0;
    dig_sum = '0;
    for (int i = 0; i < 4; i++) begin
      dig_sum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, carry};
      if (dig_sum > 5'd9) begin
        dig_sum = dig_sum + 5'd6;
        carry   = 1'b1;
      end else begin
        carry   = 1'b0;
      end
      sum[4*i +: 4] = dig_sum[3:0];
    end
    c_out = carry;
  end

endmodule

// File: rtl/fare_accumulator.sv
// Taxi-meter fare engine: base fare at start, per-km and per-wait increments in BCD.
module fare_accumulator
  import fare_pkg::*;
#(
  parameter logic [BCD_W-1:0] BASE_FARE = 16'h0080,
  parameter logic [3:0]       BASE_KM   = 4'd3,
  parameter logic [BCD_W-1:0] KM_RATE   = 16'h0020,
  parameter logic [BCD_W-1:0] WAIT_RATE = 16'h0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             km_pulse,
  input  logic             wait_tick,
  output logic [BCD_W-1:0] fare,
  output logic             running,
  output logic             overflow
);

  state_e           state_q;
  logic [BCD_W-1:0] fare_q;
  logic             running_q;
  logic             overflow_q;
  logic [3:0]       km_cnt_q;
  logic             wait_pend_q;
  logic             wait_pend_d;

  logic             km_free;
  logic             km_charge;
  logic             add_en;
  logic [BCD_W-1:0] add_inc;
  logic [BCD_W-1:0] add_sum;
  logic             add_cout;

  // Km pulses inside the included distance only count; beyond it they are charged.
  assign km_free   = km_pulse && (km_cnt_q < BASE_KM);
  assign km_charge = km_pulse && !km_free;

  // Pick the single increment for this cycle; a charged km defers any wait tick.
  always_comb begin
    add_en      = 1'b0;
    add_inc     = '0;
    wait_pend_d = wait_pend_q;
    if (km_charge) begin
      add_en      = 1'b1;
      add_inc     = KM_RATE;
      wait_pend_d = wait_pend_q | wait_tick;
    end else if (wait_pend_q) begin
      add_en      = 1'b1;
      add_inc     = WAIT_RATE;
      wait_pend_d = wait_tick;
    end else if (wait_tick) begin
      add_en      = 1'b1;
      add_inc     = WAIT_RATE;
      wait_pend_d = 1'b0;
    end
  end

  bcd_adder_4 u_adder (
    .a     (fare_q),
    .b     (add_inc),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // Trip FSM with registered fare, running and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fare_q      <= '0;
      running_q   <= 1'b0;
      overflow_q  <= 1'b0;
      km_cnt_q    <= '0;
      wait_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_RUN;
            running_q   <= 1'b1;
            fare_q      <= BASE_FARE;
            overflow_q  <= 1'b0;
            km_cnt_q    <= '0;
            wait_pend_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (km_free) begin
            km_cnt_q <= km_cnt_q + 4'd1;
          end
          // Once saturated the fare is pinned for the rest of the trip.
          if (add_en && !overflow_q) begin
            if (add_cout) begin
              fare_q     <= FARE_MAX;
              overflow_q <= 1'b1;
            end else begin
              fare_q <= add_sum;
            end
          end
          if (stop) begin
            state_q     <= ST_DONE;
            running_q   <= 1'b0;
            wait_pend_q <= 1'b0;
          end else begin
            wait_pend_q <= wait_pend_d;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign fare     = fare_q;
  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fare_accumulator.sv
// Bench for fare_accumulator: three parameterisations driven in lockstep, each against
// an integer-arithmetic trip model.
module tb_fare_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, km_pulse, wait_tick;
  logic [15:0] fare_w [3];
  logic        run_w  [3];
  logic        ovf_w  [3];

  int tests = 0;
  int fails = 0;

  // Model state, fare held as an integer count of 0.1 yuan.
  int p_base [3] = '{80, 80, 9990};
  int p_bkm  [3] = '{3, 3, 0};
  int p_kmr  [3] = '{20, 20, 20};
  int p_wr   [3] = '{10, 5, 10};
  int m_fare [3];
  int m_km   [3];
  bit m_run  [3];
  bit m_ovf  [3];
  bit m_pend [3];

  always #5 clk = ~clk;

  fare_accumulator u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .km_pulse(km_pulse),
    .wait_tick(wait_tick), .fare(fare_w[0]), .running(run_w[0]), .overflow(ovf_w[0])
  );

  fare_accumulator #(.WAIT_RATE(16'h0005)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .km_pulse(km_pulse),
    .wait_tick(wait_tick), .fare(fare_w[1]), .running(run_w[1]), .overflow(ovf_w[1])
  );

  fare_accumulator #(.BASE_FARE(16'h9990), .BASE_KM(4'd0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .km_pulse(km_pulse),
    .wait_tick(wait_tick), .fare(fare_w[2]), .running(run_w[2]), .overflow(ovf_w[2])
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_fare[i] = 0; m_km[i] = 0; m_run[i] = 0; m_ovf[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit p, input bit k, input bit w);
    for (int i = 0; i < 3; i++) begin
      int  inc;
      bit  charged;
      inc = 0;
      charged = 0;
      if (!m_run[i]) begin
        if (s) begin
          m_run[i] = 1; m_fare[i] = p_base[i]; m_km[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
        end
      end else begin
        if (k) begin
          if (m_km[i] < p_bkm[i]) m_km[i]++;
          else begin inc = p_kmr[i]; charged = 1; end
        end
        if (charged) begin
          if (w) m_pend[i] = 1;
        end else if (m_pend[i]) begin
          inc = p_wr[i]; m_pend[i] = w;
        end else if (w) begin
          inc = p_wr[i];
        end
        if (inc > 0 && !m_ovf[i]) begin
          if (m_fare[i] + inc > 9999) begin m_fare[i] = 9999; m_ovf[i] = 1; end
          else m_fare[i] = m_fare[i] + inc;
        end
        if (p) begin m_run[i] = 0; m_pend[i] = 0; end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fare%0d", i), fare_w[i], to_bcd(m_fare[i]));
      chk($sformatf("running%0d", i), {15'd0, run_w[i]}, {15'd0, m_run[i]});
      chk($sformatf("overflow%0d", i), {15'd0, ovf_w[i]}, {15'd0, m_ovf[i]});
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input bit s, input bit p, input bit k, input bit w);
    start = s; stop = p; km_pulse = k; wait_tick = w;
    @(posedge clk);
    model_step(s, p, k, w);
    #1;
    check_all();
  endtask

  initial begin
    int since_w;
    bit s, p, k, w;
    rst_n = 1'b0;
    start = 0; stop = 0; km_pulse = 0; wait_tick = 0;
    model_reset();
    #12;
    chk("reset_fare", fare_w[0], 16'h0000);
    chk("reset_running", {15'd0, run_w[0]}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Base fare and included distance.
    cyc(1, 0, 0, 0);
    chk("start_fare", fare_w[0], 16'h0080);
    chk("start_running", {15'd0, run_w[0]}, 16'd1);
    chk("ovf_base", fare_w[2], 16'h9990);
    cyc(0, 0, 1, 0);
    chk("km1_free", fare_w[0], 16'h0080);
    chk("ovf_sat", fare_w[2], 16'h9999);
    chk("ovf_flag", {15'd0, ovf_w[2]}, 16'd1);
    cyc(0, 0, 1, 0);
    chk("ovf_hold", fare_w[2], 16'h9999);
    cyc(0, 0, 1, 0);
    chk("km3_free", fare_w[0], 16'h0080);
    cyc(0, 0, 1, 0);
    chk("km4_charged", fare_w[0], 16'h0100);
    cyc(0, 0, 1, 0);
    chk("km5_charged", fare_w[0], 16'h0120);

    // Stop freezes the fare; pulses in DONE do nothing.
    cyc(0, 1, 0, 0);
    chk("stop_running", {15'd0, run_w[0]}, 16'd0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("done_frozen", fare_w[0], 16'h0120);

    // start+stop together in DONE restarts the trip.
    cyc(1, 1, 0, 0);
    chk("restart_fare", fare_w[0], 16'h0080);
    chk("restart_ovf_base", fare_w[2], 16'h9990);
    chk("restart_ovf_clear", {15'd0, ovf_w[2]}, 16'd0);

    // Waiting ticks, including a digit carry on the 0.5-yuan instance.
    cyc(0, 0, 0, 1);
    chk("wait_add", fare_w[0], 16'h0090);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("wait_0095", fare_w[1], 16'h0095);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("wait_carry", fare_w[1], 16'h0100);

    // Free km with wait in the same cycle, then a contended km+wait.
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    chk("free_km_wait", fare_w[0], 16'h0090);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("sat_km", fare_w[0], 16'h0110);
    cyc(0, 0, 1, 1);
    chk("both_km", fare_w[0], 16'h0130);
    cyc(0, 0, 0, 0);
    chk("both_pend", fare_w[0], 16'h0140);
    cyc(0, 1, 1, 0);
    chk("stop_add", fare_w[0], 16'h0160);

    // Asynchronous reset mid-trip, checked before any clock edge.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("async_fare", fare_w[0], 16'h0000);
    chk("async_running", {15'd0, run_w[0]}, 16'd0);
    chk("async_ovf", {15'd0, ovf_w[2]}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Random trips; waiting ticks kept at least two cycles apart.
    since_w = 2;
    for (int n = 0; n < 600; n++) begin
      s = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 29) == 0);
      k = ($urandom_range(0, 2) == 0);
      w = (since_w >= 2) && ($urandom_range(0, 2) == 0);
      since_w = w ? 1 : since_w + 1;
      cyc(s, p, k, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fare_accumulator.md
Name: fare_accumulator

Overview:
- Sequential fare engine for the taxi meter. Holds the running fare as 4 packed BCD digits in units of 0.1 yuan (XXX.X), covering 000.0–999.9.
- Adds the base fare at trip start, a per-km rate once the included distance is used up, and a per-waiting-tick rate.
- Drives the display/output stage. Each increment goes through one instance of the existing four-digit BCD adder.

Parameters:
BASE_FARE, 16'h0080, flag-fall fare in BCD (008.0), loaded at start
BASE_KM, 4'd3, km pulses included in the base fare (binary, 0–15)
KM_RATE, 16'h0020, BCD increment per km pulse beyond BASE_KM (002.0)
WAIT_RATE, 16'h0010, BCD increment per waiting tick (001.0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin trip
stop  in  1  one-cycle pulse, end trip
km_pulse  in  1  one-cycle pulse per km travelled
wait_tick  in  1  one-cycle pulse per waiting-time unit
fare  out  16  running fare, 4 packed BCD digits
running  out  1  high while in RUN
overflow  out  1  sticky; fare saturated at 999.9

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, fare=16'h0000, running=0, overflow=0, km_cnt=0, wait_pend=0.
- FSM states are IDLE, RUN and DONE.
  - IDLE/DONE, start=1 -> RUN. Next cycle: fare=BASE_FARE, km_cnt=0, wait_pend=0, overflow=0.
  - RUN, stop=1 -> DONE. fare freezes; wait_pend is discarded.
  - RUN, start=1 is ignored. DONE, stop=1 is ignored.
  - start and stop in the same cycle: stop wins in RUN; start wins in IDLE/DONE.
- running = (state==RUN), registered.
- Pulses in IDLE/DONE are ignored. A pulse in the same cycle as start is ignored; the base fare is loaded instead.
- km handling in RUN:
  - If km_cnt<BASE_KM, increment km_cnt and add nothing.
  - Otherwise add KM_RATE. km_cnt saturates at BASE_KM.
- wait handling in RUN: add WAIT_RATE.
- Adder: a=fare, b=selected increment, c_in=0. Result is registered into fare.
- Latency: fare reflects an accepted pulse at the first rising edge after the pulse cycle (N -> N+1).
- Only one add per cycle.
  - km_pulse and wait_tick together: km is processed; wait_pend is set.
  - A pending wait is added in the next RUN cycle with no chargeable km add. wait_pend then clears, unless a new wait_tick arrives in that same cycle, in which case it stays set.
  - A wait_tick arriving while wait_pend=1 and the adder is busy with km is dropped. Upstream guarantees waiting ticks are spaced ≥2 cycles apart.
- A km pulse within BASE_KM does not occupy the adder, so a simultaneous wait_tick is added in the same cycle.
- Overflow: if adder c_out=1, fare=16'h9999 and overflow=1.
  - fare stays 9999 for the rest of the trip; further adds are ignored.
  - overflow clears only at the next start or reset.
- A km/wait add in the same cycle as stop is still committed.
- Reset mid-RUN returns all state to reset values immediately, without waiting for a clock edge.
- Only valid BCD parameter values are permitted; no BCD checking is done on them.

Decomposition:
- Shared package, fare_pkg:
  - state encoding localparams: ST_IDLE, ST_RUN, ST_DONE
  - FARE_MAX=16'h9999
  - BCD width constant 16
- Sub-module: one instance of bcd_adder_4 (existing four-digit BCD adder). No other sub-modules.

Test Plan:
- Reset check: hold rst_n=0 mid-sim, then release -> fare=0000, running=0, overflow=0; async clear without a clock edge.
- Base distance: start -> fare=0080 at N+1, running=1. Three km_pulse -> fare stays 0080. 4th -> 0100, 5th -> 0120.
- Waiting: in RUN, wait_tick -> fare +0010 at N+1 (0080 -> 0090). Digit carry: fare 0095 with WAIT_RATE=0005 override -> 0100.
- Simultaneous pulses: km_cnt saturated, fare 0100, km_pulse+wait_tick same cycle -> 0120 at N+1, 0130 at N+2.
- Overflow: BASE_FARE=16'h9990, BASE_KM=0 override; start, then km_pulse -> fare=9999, overflow=1. Next km -> fare unchanged. New start -> 9990, overflow=0.
- Stop/restart: stop -> running=0 and fare frozen. Subsequent km_pulse/wait_tick have no effect. start+stop together in DONE -> RUN with fare=BASE_FARE.
